// File: rtl/ac97_pkg.sv
// Shared constants, types and frame packing for the AC'97 outgoing link.
// The INIT state exists only when AC97_INIT_SEQ_EN is defined.
package ac97_pkg;

  localparam int FRAME_BITS  = 256;
  localparam int SLOT0_START = 0;
  localparam int SLOT1_START = 16;
  localparam int SLOT2_START = 36;
  localparam int SLOT3_START = 56;
  localparam int SLOT4_START = 76;
  localparam int SLOT0_W     = 16;
  localparam int SLOTN_W     = 20;
  localparam int DATA_BITS   = SLOT4_START + SLOTN_W;  // bits 96..255 are always zero
  localparam int SYNC_BITS   = 16;
  localparam int LATCH_CNT   = FRAME_BITS - 2;

  // Tag positions inside the 16-bit slot0 word (bit 15 goes out first)
  localparam int TAG_VALID = 15;
  localparam int TAG_SLOT1 = 14;
  localparam int TAG_SLOT2 = 13;
  localparam int TAG_SLOT3 = 12;
  localparam int TAG_SLOT4 = 11;

  localparam logic [6:0]  INIT_ADDR0 = 7'h02;
  localparam logic [15:0] INIT_DATA0 = 16'h0000;
  localparam logic [6:0]  INIT_ADDR1 = 7'h04;
  localparam logic [15:0] INIT_DATA1 = 16'h0000;
  localparam logic [6:0]  INIT_ADDR2 = 7'h18;
  localparam logic [15:0] INIT_DATA2 = 16'h0808;
  localparam logic [6:0]  INIT_ADDR3 = 7'h2C;
  localparam logic [15:0] INIT_DATA3 = 16'hBB80;

  typedef enum logic [1:0] {
    ST_STARTUP = 2'd0,
    ST_RUN     = 2'd1
`ifdef AC97_INIT_SEQ_EN
    ,ST_INIT   = 2'd2
`endif
  } ac97_state_e;

  typedef struct packed {
    logic        cmd_tag;
    logic        pcm_tag;
    logic [6:0]  addr;
    logic [15:0] data;
    logic [19:0] left;
    logic [19:0] right;
  } frame_t;

  function automatic logic [DATA_BITS-1:0] pack_frame(input frame_t f);
    logic [SLOT0_W-1:0] slot0;
    slot0            = '0;
    slot0[TAG_VALID] = f.cmd_tag | f.pcm_tag;
    slot0[TAG_SLOT1] = f.cmd_tag;
    slot0[TAG_SLOT2] = f.cmd_tag;
    slot0[TAG_SLOT3] = f.pcm_tag;
    slot0[TAG_SLOT4] = f.pcm_tag;
    return {slot0, 1'b0, f.addr, 12'h000, f.data, 4'h0, f.left, f.right};
  endfunction

endpackage

// File: rtl/ac97_frame_controller_if.sv
// Command and PCM valid/ready handshakes between the audio/config logic and the link controller.
interface ac97_frame_controller_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [6:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic        pcm_valid;
  logic        pcm_ready;
  logic [19:0] pcm_left;
  logic [19:0] pcm_right;

  modport master (
    output cmd_valid, cmd_addr, cmd_data, pcm_valid, pcm_left, pcm_right,
    input  cmd_ready, pcm_ready
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_data, pcm_valid, pcm_left, pcm_right,
    output cmd_ready, pcm_ready
  );
endinterface

// File: rtl/ac97_init_rom.sv
// Codec register writes issued once after startup when AC97_INIT_SEQ_EN is defined.
module ac97_init_rom
  import ac97_pkg::*;
(
  input  logic [1:0]  idx_i,
  output logic [6:0]  addr_o,
  output logic [15:0] data_o
);

  always_comb begin
    case (idx_i)
      2'd0:    begin addr_o = INIT_ADDR0; data_o = INIT_DATA0; end
      2'd1:    begin addr_o = INIT_ADDR1; data_o = INIT_DATA1; end
      2'd2:    begin addr_o = INIT_ADDR2; data_o = INIT_DATA2; end
      default: begin addr_o = INIT_ADDR3; data_o = INIT_DATA3; end
    endcase
  end

endmodule

// File: rtl/ac97_frame_controller.sv
// AC'97 SYNC/SDATA_OUT frame generator with command and stereo PCM handshakes.
// Define AC97_INIT_SEQ_EN to insert the four-write codec INIT sequence before RUN.
module ac97_frame_controller
  import ac97_pkg::*;
#(
  parameter int unsigned STARTUP_FRAMES = 2
) (
  input  logic                          RawBitClock,
  input  logic                          RST,
  ac97_frame_controller_if.slave        host,
  output logic                          SYNC,
  output logic                          SDATA_OUT,
  output logic                          frame_start,
  output logic                          pcm_underrun,
  output logic                          init_done
);

  localparam logic [7:0] LAST_WRAP = 8'(STARTUP_FRAMES - 1);

  logic [7:0]           bit_cnt_q, cnt_next;
  ac97_state_e          state_q, state_d;
  logic [7:0]           wrap_cnt_q, wrap_cnt_d;
  frame_t               frame_q, frame_d;
  logic                 sync_q, sync_d;
  logic                 sdata_q, sdata_d;
  logic                 frame_start_q, frame_start_d;
  logic                 underrun_q, underrun_d;
  logic                 init_done_q, init_done_d;
  logic                 ready_q, ready_d;
  logic                 latch_edge, wrap, cmd_acc, pcm_acc;
  logic [DATA_BITS-1:0] frame_vec;
  logic [6:0]           data_idx;

`ifdef AC97_INIT_SEQ_EN
  logic [1:0]  init_idx_q, init_idx_d;
  logic [6:0]  rom_addr;
  logic [15:0] rom_data;

  ac97_init_rom u_init_rom (
    .idx_i  (init_idx_q),
    .addr_o (rom_addr),
    .data_o (rom_data)
  );

  localparam ac97_state_e AFTER_STARTUP = ST_INIT;
`else
  localparam ac97_state_e AFTER_STARTUP = ST_RUN;
`endif

  assign cnt_next   = bit_cnt_q + 8'd1;
  assign latch_edge = (bit_cnt_q == 8'(LATCH_CNT));
  assign wrap       = (bit_cnt_q == 8'(FRAME_BITS - 1));
  assign cmd_acc    = host.cmd_valid && ready_q;
  assign pcm_acc    = host.pcm_valid && ready_q;
  assign frame_vec  = pack_frame(frame_q);
  assign data_idx   = 7'(DATA_BITS - 1) - cnt_next[6:0];

  always_comb begin
    // NOTE: every _d takes its hold value first, so no branch can leave one unassigned and infer a latch.
    state_d    = state_q;
    wrap_cnt_d = wrap_cnt_q;
    frame_d    = frame_q;
`ifdef AC97_INIT_SEQ_EN
    init_idx_d = init_idx_q;
`endif
    // Each frame is rebuilt from scratch at the latch point; absent traffic leaves zeros and clear tags.
    if (latch_edge) frame_d = '0;

    case (state_q)
      ST_STARTUP: begin
        if (wrap) begin
          wrap_cnt_d = wrap_cnt_q + 8'd1;
          if (wrap_cnt_q == LAST_WRAP) state_d = AFTER_STARTUP;
        end
      end
`ifdef AC97_INIT_SEQ_EN
      ST_INIT: begin
        if (latch_edge) begin
          frame_d.cmd_tag = 1'b1;
          frame_d.addr    = rom_addr;
          frame_d.data    = rom_data;
          init_idx_d      = init_idx_q + 2'd1;
          if (init_idx_q == 2'd3) state_d = ST_RUN;
        end
      end
`endif
      ST_RUN: begin
        if (latch_edge) begin
          if (cmd_acc) begin
            frame_d.cmd_tag = 1'b1;
            frame_d.addr    = host.cmd_addr;
            frame_d.data    = host.cmd_data;
          end
          if (pcm_acc) begin
            frame_d.pcm_tag = 1'b1;
            frame_d.left    = host.pcm_left;
            frame_d.right   = host.pcm_right;
          end
        end
      end
      default: state_d = ST_STARTUP;
    endcase

    // Outputs are computed for the count the next edge lands on, so each register lines up with bit_cnt.
    ready_d       = (state_q == ST_RUN) && (cnt_next == 8'(LATCH_CNT));
    underrun_d    = (state_q == ST_RUN) && latch_edge && !pcm_acc;
    init_done_d   = (state_d == ST_RUN);
    frame_start_d = (cnt_next == 8'd0);
    // SYNC can only start at 255, so the first pulse after reset is never truncated.
    sync_d        = (cnt_next == 8'(FRAME_BITS - 1)) || (sync_q && (cnt_next < 8'(SYNC_BITS - 1)));
    sdata_d       = (cnt_next < 8'(DATA_BITS)) ? frame_vec[data_idx] : 1'b0;
  end

  always_ff @(posedge RawBitClock or negedge RST) begin
    if (!RST) begin
      // NOTE: the frame register is reset as well, so a command latched before RST can never reach the wire.
      bit_cnt_q     <= '0;
      state_q       <= ST_STARTUP;
      wrap_cnt_q    <= '0;
      frame_q       <= '0;
      sync_q        <= 1'b0;
      sdata_q       <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      init_done_q   <= 1'b0;
      ready_q       <= 1'b0;
`ifdef AC97_INIT_SEQ_EN
      init_idx_q    <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      bit_cnt_q     <= cnt_next;
      state_q       <= state_d;
      wrap_cnt_q    <= wrap_cnt_d;
      frame_q       <= frame_d;
      sync_q        <= sync_d;
      sdata_q       <= sdata_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
      init_done_q   <= init_done_d;
      ready_q       <= ready_d;
`ifdef AC97_INIT_SEQ_EN
      init_idx_q    <= init_idx_d;
`endif
    end
  end

  assign SYNC           = sync_q;
  assign SDATA_OUT      = sdata_q;
  assign frame_start    = frame_start_q;
  assign pcm_underrun   = underrun_q;
  assign init_done      = init_done_q;
  assign host.cmd_ready = ready_q;
  assign host.pcm_ready = ready_q;

endmodule

// File: doc/ac97_frame_controller.md
# ac97_frame_controller

AC'97 link controller that owns the outgoing SYNC/SDATA_OUT serial link to the codec. Builds one 256-bit frame per 256 bit clocks: tag slot, command address/data slots for control-register writes, and left/right PCM slots. Accepts register-write commands and stereo samples from the rest of the design over valid/ready handshakes. Sits between the audio datapath / config logic and the codec pins.

## Interface
- STARTUP_FRAMES, 2: whole frames after reset sent with all tags zero before accepting traffic
- RawBitClock  in  1  codec bit clock (~12.288 MHz); all logic on posedge
- RST  in  1  reset; asynchronous, active-low
- SYNC  out  1  frame sync to codec
- SDATA_OUT  out  1  serial frame data, MSB-first per slot
- cmd_valid  in  1  register-write request
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_addr  in  7  codec register address
- cmd_data  in  16  register write value
- pcm_valid  in  1  stereo sample available
- pcm_ready  out  1  sample accepted when high with pcm_valid
- pcm_left, pcm_right  in  20  PCM samples, two's complement
- frame_start  out  1  one-cycle pulse at bit_cnt==0
- pcm_underrun  out  1  one-cycle pulse when a RUN frame goes out without PCM
- init_done  out  1  high once in RUN

## Operation
- bit_cnt: 8-bit, free-running 0..255, wraps 255→0.
- Frame bit n is driven on SDATA_OUT while bit_cnt==n. Bits 0-15 slot0, 16-35 slot1, 36-55 slot2, 56-75 slot3, 76-95 slot4, 96-255 zero.
- Slot0: bit0 frame valid (OR of slot tags), bit1 slot1 valid, bit2 slot2 valid, bit3 slot3 valid, bit4 slot4 valid, bits 5-15 zero.
- Slot1: {1'b0 (write), cmd_addr, 12'h000}. Slot2: {cmd_data, 4'h0}. Slot3: pcm_left. Slot4: pcm_right.
- SYNC high while bit_cnt ∈ {255, 0..14} (16 bits, rising one bit before slot0 MSB).
- States: STARTUP → (INIT) → RUN.
  - STARTUP: counts STARTUP_FRAMES wraps; tags zero; readys low.
  - RUN: at bit_cnt==254, cmd_ready and pcm_ready pulse high one cycle. Accepted command sets slot1/slot2 tags for the next frame; accepted sample sets slot3/slot4 tags. No command → slot1/2 tags 0, data zero. No sample → slot3/4 tags 0, zeros, pcm_underrun pulses at bit_cnt==255.
- Frame content latched at bit_cnt==254; inputs changing later do not affect the frame in flight.
- Read commands not supported; slot1 bit 19 always 0.

## Timing
- Reset values: SYNC 0, SDATA_OUT 0, cmd_ready 0, pcm_ready 0, frame_start 0, pcm_underrun 0, init_done 0, bit_cnt 0, state STARTUP.
- SYNC held low after reset until bit_cnt first reaches 255 (no truncated first pulse).
- All outputs registered; SYNC/SDATA_OUT change only on posedge RawBitClock.
- Handshake-to-wire latency: accepted at bit_cnt 254; slot1 MSB on wire 18 cycles later (bit_cnt 16); PCM left MSB 58 cycles later.
- Max throughput: one command and one sample per frame.
- RST assertion mid-frame: outputs to reset values immediately; in-flight frame discarded, latched command/sample dropped; re-enters STARTUP.

## Configuration
- AC97_INIT_SEQ_EN defined: INIT state between STARTUP and RUN sends four writes, one per frame: 0x02←0x0000, 0x04←0x0000, 0x18←0x0808, 0x2C←0xBB80; cmd_ready and pcm_ready stay low; init_done rises when entering RUN after the fourth frame.
- Not defined: STARTUP → RUN directly; INIT state and ROM absent.

## Structure
- Package ac97_pkg: FRAME_BITS=256, slot start offsets (0,16,36,56,76), slot widths, tag bit positions, state enum, init register address/value constants.
- Sub-module ac97_init_rom (2-bit index → {addr, data}), instantiated only under AC97_INIT_SEQ_EN.

## Test plan
- Reset released, no traffic, STARTUP_FRAMES=2 → no SYNC until first bit_cnt 255; frames of 256 cycles, SYNC high 16 cycles; slot0 all zero; init_done after 2 frames (macro off).
- cmd 0x02/0x8000 offered → accepted at bit_cnt 254; next frame slot0 = 16'hE000 (valid, slot1, slot2), slot1 = 20'h02000, slot2 = 20'h80000; codec model ControlRegs[2] reads 0x8000.
- pcm_left 20'h12345, pcm_right 20'hFEDCB held valid → one accept per frame, slot0 tags bits 0,3,4 set, slots 3/4 carry exact values.
- pcm_valid low in RUN → pcm_underrun pulse at bit_cnt 255, slot3/4 zero, tags 3/4 clear.
- RST pulsed low at bit_cnt 40 during a command frame → SYNC/SDATA_OUT 0 at once, command dropped, STARTUP restarts.
- AC97_INIT_SEQ_EN defined → four init frames, codec regs 0x02=0x0000, 0x04=0x0000, 0x18=0x0808, 0x2C=0xBB80; cmd_ready low until init_done.
